datapath_result_display: RTL and testbench

- Downstream consumer of the top-level datapath's architectural result registers v0/v1.
- Takes a stable snapshot of the selected register and scans it as 8 hex digits onto a multiplexed, active-low, 8-digit seven-segment display.
- Lets the board show program results while the processor runs.
- Contains a stability filter, a refresh prescaler, and a digit-scan counter.

---
 rtl/display_pkg.sv | 16 +
 rtl/hex_to_seg7.sv | 13 +
 rtl/datapath_result_display.sv | 126 ++++++++++++
 tb/tb_datapath_result_display.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment result display: digit count,
// active-low gfedcba hex glyph table and the blank code.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [3:0] nibble_t;

    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment (gfedcba) decoder.
module hex_to_seg7
    import display_pkg::*;
(
    input  nibble_t    nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX7[nibble_i];
    end

endmodule

// File: rtl/datapath_result_display.sv
// Snapshots v0/v1 through a stability filter and scans it as 8 hex digits.
// Optional macro DISPLAY_LEADING_ZERO_BLANK_EN blanks leading-zero digits.
module datapath_result_display
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [31:0]           v0,
    input  logic [31:0]           v1,
    input  logic                  ShowV1,
    input  logic                  Freeze,
    output logic [NUM_DIGITS-1:0] An,
    output logic [6:0]            Seg,
    output logic                  Dp,
    output logic                  Changed
);

    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
    localparam int unsigned STAB_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(STABLE_CYCLES - 1);

    logic                  sel_q,   sel_d;
    logic [31:0]           snap_q,  snap_d;
    logic [31:0]           cand_q,  cand_d;
    logic [STAB_W-1:0]     stab_q,  stab_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [NUM_DIGITS-1:0] an_q,    an_d;
    logic [6:0]            seg_q,   seg_d;
    logic                  dp_q,    dp_d;
    logic                  chg_q,   chg_d;

    logic [31:0] src;
    nibble_t     nib;
    logic [6:0]  seg_hex;

    hex_to_seg7 u_hex (
        .nibble_i (nib),
        .seg_o    (seg_hex)
    );

    always_comb begin
        src     = ShowV1 ? v1 : v0;
        sel_d   = ShowV1;
        snap_d  = snap_q;
        cand_d  = cand_q;
        stab_d  = stab_q;
        chg_d   = 1'b0;

        // A source toggle captures immediately, even while frozen.
        if (ShowV1 != sel_q) begin
            snap_d = src;
            cand_d = src;
            stab_d = '0;
            chg_d  = 1'b1;
        end else if (src != cand_q) begin
            cand_d = src;
            stab_d = '0;
        end else if (cand_q != snap_q && stab_q == STAB_LAST && !Freeze) begin
            snap_d = cand_q;
            chg_d  = 1'b1;
        end else if (stab_q < STAB_LAST) begin
            stab_d = stab_q + 1'b1;
        end

        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
            idx_d   = idx_q;
        end

        // Outputs are built from next-state values so they register alongside them.
        nib  = snap_d[{idx_d, 2'b00} +: 4];
        an_d = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d);
        dp_d = ~((idx_d == '0) && sel_d);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        if ((idx_d != '0) && ((snap_d >> {idx_d, 2'b00}) == '0)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_hex;
        end
`else
        seg_d = seg_hex;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_q   <= 1'b0;
            snap_q  <= '0;
            cand_q  <= '0;
            stab_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            chg_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            chg_q   <= chg_d;
        end
    end

    assign An      = an_q;
    assign Seg     = seg_q;
    assign Dp      = dp_q;
    assign Changed = chg_q;

endmodule

// File: tb/tb_datapath_result_display.sv
// Directed bench for datapath_result_display with REFRESH_DIV=4, STABLE_CYCLES=3.
module tb_datapath_result_display;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] v0, v1;
    logic        ShowV1, Freeze;
    logic [7:0]  An;
    logic [6:0]  Seg;
    logic        Dp;
    logic        Changed;

    int errors = 0;
    int checks = 0;

    datapath_result_display #(
        .REFRESH_DIV   (4),
        .STABLE_CYCLES (3)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .v0      (v0),
        .v1      (v1),
        .ShowV1  (ShowV1),
        .Freeze  (Freeze),
        .An      (An),
        .Seg     (Seg),
        .Dp      (Dp),
        .Changed (Changed)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        v0 = '0; v1 = '0; ShowV1 = 1'b0; Freeze = 1'b0;
        Reset = 1'b1;
        tick_n(2);
        checks++; if (An !== 8'hFF) begin errors++; $display("FAIL reset_an got=%h exp=ff", An); end
        checks++; if (Seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", Seg); end
        checks++; if (Dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", Dp); end
        checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL reset_changed got=%b exp=0", Changed); end
        Reset = 1'b0;
        tick();
        checks++; if (An !== 8'hFE) begin errors++; $display("FAIL rel_an got=%h exp=fe", An); end
        checks++; if (Seg !== 7'h40) begin errors++; $display("FAIL rel_seg got=%h exp=40", Seg); end
        tick_n(3);
        checks++; if (An !== 8'hFD) begin errors++; $display("FAIL step_an got=%h exp=fd", An); end
        tick_n(24);
        checks++; if (An !== 8'h7F) begin errors++; $display("FAIL digit7_an got=%h exp=7f", An); end
        tick_n(4);
        checks++; if (An !== 8'hFE) begin errors++; $display("FAIL wrap_an got=%h exp=fe", An); end
    endtask

    task automatic test_capture();
        logic [6:0] exp_seg [8];
        int cur;
        exp_seg = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        v0 = '0; ShowV1 = 1'b0; Freeze = 1'b0;
        do_reset();
        v0 = 32'h1234_5678;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL cap_pre_changed edge=%0d got=%b exp=0", e, Changed); end
        end
        tick();
        checks++; if (Changed !== 1'b1) begin errors++; $display("FAIL cap_changed got=%b exp=1", Changed); end
        checks++; if (An !== 8'hFD) begin errors++; $display("FAIL cap_an got=%h exp=fd", An); end
        checks++; if (Seg !== 7'h78) begin errors++; $display("FAIL cap_seg got=%h exp=78", Seg); end
        tick();
        checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL cap_pulse_end got=%b exp=0", Changed); end
        cur = 5;
        for (int d = 2; d <= 8; d++) begin
            tick_n(4 * d - cur);
            cur = 4 * d;
            checks++; if (An !== ~(8'h01 << (d % 8))) begin errors++; $display("FAIL scan_an digit=%0d got=%h", d % 8, An); end
            checks++; if (Seg !== exp_seg[d % 8]) begin errors++; $display("FAIL scan_seg digit=%0d got=%h exp=%h", d % 8, Seg, exp_seg[d % 8]); end
        end
    endtask

    task automatic test_glitch();
        v0 = '0; ShowV1 = 1'b0; Freeze = 1'b0;
        do_reset();
        v0 = 32'd5; tick();
        v0 = 32'd6; tick();
        v0 = 32'd5; tick();
        checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL glitch_e3 got=%b exp=0", Changed); end
        for (int e = 4; e <= 5; e++) begin
            tick();
            checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL glitch_hold edge=%0d got=%b exp=0", e, Changed); end
        end
        tick();
        checks++; if (Changed !== 1'b1) begin errors++; $display("FAIL glitch_capture got=%b exp=1", Changed); end
    endtask

    task automatic test_freeze();
        v0 = '0; ShowV1 = 1'b0; Freeze = 1'b0;
        do_reset();
        Freeze = 1'b1;
        v0 = 32'h0000_ABCD;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL frz_changed edge=%0d got=%b exp=0", e, Changed); end
            if (e == 3) begin
                checks++; if (Seg !== 7'h40) begin errors++; $display("FAIL frz_snap_held got=%h exp=40", Seg); end
            end
        end
        Freeze = 1'b0;
        tick();
        checks++; if (Changed !== 1'b1) begin errors++; $display("FAIL frz_release_changed got=%b exp=1", Changed); end
        checks++; if (Seg !== 7'h03) begin errors++; $display("FAIL frz_release_seg got=%h exp=03", Seg); end
        tick();
        checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL frz_pulse_end got=%b exp=0", Changed); end
        checks++; if (Seg !== 7'h08) begin errors++; $display("FAIL frz_digit3 got=%h exp=08", Seg); end
    endtask

    task automatic test_showv1();
        logic [6:0] exp_d1;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        exp_d1 = 7'h7F;
`else
        exp_d1 = 7'h40;
`endif
        v0 = '0; v1 = '0; ShowV1 = 1'b0; Freeze = 1'b0;
        do_reset();
        Freeze = 1'b1;
        v1 = 32'h0000_000F;
        ShowV1 = 1'b1;
        tick();
        checks++; if (Changed !== 1'b1) begin errors++; $display("FAIL sel_changed got=%b exp=1", Changed); end
        checks++; if (Seg !== 7'h0E) begin errors++; $display("FAIL sel_seg got=%h exp=0e", Seg); end
        checks++; if (Dp !== 1'b0) begin errors++; $display("FAIL sel_dp got=%b exp=0", Dp); end
        tick();
        checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL sel_pulse_end got=%b exp=0", Changed); end
        tick_n(2);
        checks++; if (Seg !== exp_d1) begin errors++; $display("FAIL sel_digit1_seg got=%h exp=%h", Seg, exp_d1); end
        checks++; if (Dp !== 1'b1) begin errors++; $display("FAIL sel_digit1_dp got=%b exp=1", Dp); end
        ShowV1 = 1'b0;
        Freeze = 1'b0;
    endtask

    task automatic test_reset_mid();
        v0 = '0; ShowV1 = 1'b0; Freeze = 1'b0;
        do_reset();
        v0 = 32'h1234_5678;
        tick_n(21);
        checks++; if (An !== 8'hDF) begin errors++; $display("FAIL mid_an got=%h exp=df", An); end
        checks++; if (Seg !== 7'h30) begin errors++; $display("FAIL mid_seg got=%h exp=30", Seg); end
        Reset = 1'b1;
        tick();
        checks++; if (An !== 8'hFF) begin errors++; $display("FAIL mid_rst_an got=%h exp=ff", An); end
        checks++; if (Seg !== 7'h7F) begin errors++; $display("FAIL mid_rst_seg got=%h exp=7f", Seg); end
        checks++; if (Changed !== 1'b0) begin errors++; $display("FAIL mid_rst_changed got=%b exp=0", Changed); end
        Reset = 1'b0;
        v0 = '0;
        tick();
        checks++; if (An !== 8'hFE) begin errors++; $display("FAIL mid_post_an got=%h exp=fe", An); end
        checks++; if (Seg !== 7'h40) begin errors++; $display("FAIL mid_post_snap got=%h exp=40", Seg); end
    endtask

    initial begin
        Reset = 1'b1; v0 = '0; v1 = '0; ShowV1 = 1'b0; Freeze = 1'b0;
        test_reset();
        test_capture();
        test_glitch();
        test_freeze();
        test_showv1();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
